// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings and ALU operation enum shared by the
// fetch_execute core.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_t;
endpackage

// File: rtl/fetch_execute_if.sv
// fetch_execute_if: program-load, debug-read and control/PC observation bus
// of the fetch_execute core; slave is the core side.
interface fetch_execute_if #(parameter int IMEM_AW = 6);
  logic               imem_we;
  logic [IMEM_AW-1:0] imem_waddr;
  logic [31:0]        imem_wdata;
  logic [4:0]         dbg_raddr;
  logic [31:0]        dbg_rdata;
  logic [29:0]        pc;
  logic [29:0]        pc_seq;
  logic [31:0]        inst;
  logic               branch;
  logic               jump;
  logic               zero;
  modport master (
    output imem_we, imem_waddr, imem_wdata, dbg_raddr,
    input  dbg_rdata, pc, pc_seq, inst, branch, jump, zero
  );
  modport slave (
    input  imem_we, imem_waddr, imem_wdata, dbg_raddr,
    output dbg_rdata, pc, pc_seq, inst, branch, jump, zero
  );
endinterface

// File: rtl/execute.sv
// execute: decode, 32x32 register file, ALU and data memory; retires one
// instruction per clock.
module execute
  import mips_pkg::*;
#(
  parameter int DMEM_AW = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [4:0]  dbg_raddr,
  output logic [31:0] dbg_rdata,
  output logic        branch,
  output logic        jump,
  output logic        zero
);
  logic [31:0] regs [32];
  logic [31:0] dmem [2**DMEM_AW];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic [31:0] imm, a, rt_val, b, result, wdata;
  logic [DMEM_AW-1:0] addr;
  alu_op_t     alu_op;
  logic        use_imm, reg_we, mem_we, mem_rd;
  logic        unused_shamt;
  assign op           = inst[31:26];
  assign rs           = inst[25:21];
  assign rt           = inst[20:16];
  assign rd           = inst[15:11];
  assign funct        = inst[5:0];
  assign unused_shamt = ^inst[10:6];
  assign imm          = {{16{inst[15]}}, inst[15:0]};
  assign a            = regs[rs];
  assign rt_val       = regs[rt];
  assign dbg_rdata    = regs[dbg_raddr];
  assign b            = use_imm ? imm : rt_val;
  assign addr         = result[DMEM_AW+1:2];
  assign wdata        = mem_rd ? dmem[addr] : result;
  assign zero         = result == 32'd0;
  // Unknown opcodes and unknown R-type functs fall through with no writes.
  always_comb begin
    alu_op  = ALU_ADD;
    use_imm = 1'b0;
    reg_we  = 1'b0;
    dst     = rt;
    mem_we  = 1'b0;
    mem_rd  = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    case (op)
      OP_RTYPE: begin
        dst    = rd;
        reg_we = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin
        use_imm = 1'b1;
        reg_we  = 1'b1;
      end
      OP_LW: begin
        use_imm = 1'b1;
        reg_we  = 1'b1;
        mem_rd  = 1'b1;
      end
      OP_SW: begin
        use_imm = 1'b1;
        mem_we  = 1'b1;
      end
      OP_BEQ: begin
        alu_op = ALU_SUB;
        branch = 1'b1;
      end
      OP_J:    jump = 1'b1;
      default: ;
    endcase
  end
  always_comb
    result = alu_op == ALU_SUB ? a - b :
             alu_op == ALU_AND ? a & b :
             alu_op == ALU_OR  ? a | b :
             alu_op == ALU_SLT ? {31'd0, $signed(a) < $signed(b)} : a + b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < 32; i++) regs[i] <= '0;
    else if (reg_we && dst != 5'd0) regs[dst] <= wdata;
  always_ff @(posedge clk)
    if (mem_we) dmem[addr] <= rt_val;
endmodule

// File: rtl/fetch.sv
// fetch: word PC register, instruction memory with load port, next-PC select
// (jump over taken branch over sequential).
module fetch #(
  parameter int IMEM_AW = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               imem_we,
  input  logic [IMEM_AW-1:0] imem_waddr,
  input  logic [31:0]        imem_wdata,
  input  logic               branch,
  input  logic               jump,
  input  logic               zero,
  output logic [29:0]        pc,
  output logic [29:0]        pc_seq,
  output logic [31:0]        inst
);
  logic [31:0] imem [2**IMEM_AW];
  logic [29:0] pc_next;
  assign inst    = imem[pc[IMEM_AW-1:0]];
  assign pc_seq  = pc + 30'd1;
  assign pc_next = jump ? {pc_seq[29:26], inst[25:0]} :
                   (branch & zero) ? pc_seq + {{14{inst[15]}}, inst[15:0]} : pc_seq;
  // Program load works while the core is held in reset.
  always_ff @(posedge clk)
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc <= '0;
    else pc <= pc_next;
endmodule

// File: rtl/fetch_execute.sv
// fetch_execute: single-cycle MIPS-subset core; wires fetch to execute and
// exposes both through fetch_execute_if.
module fetch_execute
  import mips_pkg::*;
#(
  parameter int IMEM_AW = 6,
  parameter int DMEM_AW = 6
) (
  input logic            clk,
  input logic            rst_n,
  fetch_execute_if.slave bus
);
  fetch #(.IMEM_AW(IMEM_AW)) u_fetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .imem_we   (bus.imem_we),
    .imem_waddr(bus.imem_waddr),
    .imem_wdata(bus.imem_wdata),
    .branch    (bus.branch),
    .jump      (bus.jump),
    .zero      (bus.zero),
    .pc        (bus.pc),
    .pc_seq    (bus.pc_seq),
    .inst      (bus.inst)
  );
  execute #(.DMEM_AW(DMEM_AW)) u_execute (
    .clk      (clk),
    .rst_n    (rst_n),
    .inst     (bus.inst),
    .dbg_raddr(bus.dbg_raddr),
    .dbg_rdata(bus.dbg_rdata),
    .branch   (bus.branch),
    .jump     (bus.jump),
    .zero     (bus.zero)
  );
endmodule

// File: tb/tb_fetch_execute.sv
// tb_fetch_execute: directed programs with hand-computed register, PC and
// control expectations for the fetch_execute core.
module tb_fetch_execute;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] prog [64];
  fetch_execute_if #(.IMEM_AW(6)) bus ();
  fetch_execute #(.IMEM_AW(6), .DMEM_AW(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs, logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'd0, fn};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_reg(logic [4:0] r, logic [31:0] exp);
    bus.dbg_raddr = r;
    #1;
    chk($sformatf("reg$%0d", r), bus.dbg_rdata, exp);
  endtask
  task automatic load_prog();
    for (int i = 0; i < 64; i++) begin
      bus.imem_we    = 1'b1;
      bus.imem_waddr = 6'(i);
      bus.imem_wdata = prog[i];
      tick();
    end
    bus.imem_we = 1'b0;
  endtask
  task automatic wait_pc(logic [29:0] target);
    int n = 0;
    while (bus.pc !== target && n < 300) begin
      tick();
      n++;
    end
    chk("wait_pc", {2'b00, bus.pc}, {2'b00, target});
  endtask
  initial begin
    bus.imem_we = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;
    bus.dbg_raddr = '0;
    // Program A: ALU ops, memory, branches, $0 write, undefined opcode
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0]  = enc_i(6'b001000, 5'd0, 5'd1, 16'd5);
    prog[1]  = enc_i(6'b001000, 5'd0, 5'd2, 16'hFFFD);
    prog[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'b100000);
    prog[3]  = enc_r(5'd2, 5'd1, 5'd4, 6'b100010);
    prog[4]  = enc_r(5'd2, 5'd1, 5'd5, 6'b101010);
    prog[5]  = enc_r(5'd1, 5'd2, 5'd6, 6'b100100);
    prog[6]  = enc_r(5'd1, 5'd2, 5'd7, 6'b100101);
    prog[7]  = enc_i(6'b101011, 5'd0, 5'd1, 16'd8);
    prog[8]  = enc_i(6'b100011, 5'd0, 5'd8, 16'd8);
    prog[9]  = enc_i(6'b100011, 5'd0, 5'd9, 16'd9);
    prog[10] = enc_i(6'b000100, 5'd1, 5'd1, 16'd2);
    prog[11] = enc_i(6'b001000, 5'd0, 5'd10, 16'd1);
    prog[12] = enc_i(6'b001000, 5'd0, 5'd10, 16'd2);
    prog[13] = enc_i(6'b000100, 5'd1, 5'd2, 16'd2);
    prog[14] = enc_i(6'b001000, 5'd0, 5'd0, 16'd7);
    prog[15] = 32'hFFFF_FFFF;
    prog[16] = enc_i(6'b000100, 5'd0, 5'd0, 16'hFFFF);
    #2;
    load_prog();
    chk("reset_pc", {2'b00, bus.pc}, 32'd0);
    for (int r = 0; r < 32; r++) chk_reg(5'(r), 32'd0);
    rst_n = 1'b1;
    chk("pc_0", {2'b00, bus.pc}, 32'd0);
    tick();
    chk("pc_1", {2'b00, bus.pc}, 32'd1);
    tick();
    chk("pc_2", {2'b00, bus.pc}, 32'd2);
    repeat (8) tick();
    chk("pc_10", {2'b00, bus.pc}, 32'd10);
    chk("beq_t_branch", {31'd0, bus.branch}, 32'd1);
    chk("beq_t_zero", {31'd0, bus.zero}, 32'd1);
    chk("beq_t_jump", {31'd0, bus.jump}, 32'd0);
    tick();
    chk("beq_t_target", {2'b00, bus.pc}, 32'd13);
    chk("beq_nt_zero", {31'd0, bus.zero}, 32'd0);
    tick();
    chk("beq_nt_target", {2'b00, bus.pc}, 32'd14);
    tick();
    chk("undef_inst", bus.inst, 32'hFFFF_FFFF);
    tick();
    chk("undef_next", {2'b00, bus.pc}, 32'd16);
    tick();
    chk("self_loop_a", {2'b00, bus.pc}, 32'd16);
    chk_reg(5'd1, 32'd5);
    chk_reg(5'd2, 32'hFFFF_FFFD);
    chk_reg(5'd3, 32'd2);
    chk_reg(5'd4, 32'hFFFF_FFF8);
    chk_reg(5'd5, 32'd1);
    chk_reg(5'd6, 32'd5);
    chk_reg(5'd7, 32'hFFFF_FFFD);
    chk_reg(5'd8, 32'd5);
    chk_reg(5'd9, 32'd5);
    chk_reg(5'd10, 32'd0);
    chk_reg(5'd0, 32'd0);
    chk_reg(5'd31, 32'd0);
    // Mid-cycle asynchronous reset
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", {2'b00, bus.pc}, 32'd0);
    chk_reg(5'd1, 32'd0);
    // Program B: retained dmem, jump loop, overflow doubling, self loop at 20
    for (int i = 0; i < 64; i++) prog[i] = 32'd0;
    prog[0]  = enc_i(6'b001000, 5'd0, 5'd11, 16'h7FFF);
    prog[1]  = enc_i(6'b100011, 5'd0, 5'd12, 16'd8);
    prog[2]  = enc_i(6'b001000, 5'd0, 5'd13, 16'd18);
    prog[4]  = enc_r(5'd11, 5'd11, 5'd11, 6'b100000);
    prog[5]  = enc_i(6'b001000, 5'd13, 5'd13, 16'hFFFF);
    prog[6]  = enc_i(6'b000100, 5'd13, 5'd0, 16'd13);
    prog[7]  = {6'b000010, 26'd4};
    prog[20] = enc_i(6'b000100, 5'd0, 5'd0, 16'hFFFF);
    @(posedge clk);
    #1;
    load_prog();
    rst_n = 1'b1;
    chk("restart_pc", {2'b00, bus.pc}, 32'd0);
    wait_pc(30'd7);
    chk("j_jump", {31'd0, bus.jump}, 32'd1);
    chk("j_branch", {31'd0, bus.branch}, 32'd0);
    chk("j_pc_seq", {2'b00, bus.pc_seq}, 32'd8);
    tick();
    chk("j_target", {2'b00, bus.pc}, 32'd4);
    wait_pc(30'd20);
    chk("loop_branch", {31'd0, bus.branch}, 32'd1);
    chk("loop_zero", {31'd0, bus.zero}, 32'd1);
    tick();
    chk("self_loop_b", {2'b00, bus.pc}, 32'd20);
    chk_reg(5'd11, 32'hFFFC_0000);
    chk_reg(5'd12, 32'd5);
    chk_reg(5'd13, 32'd0);
    chk_reg(5'd1, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
